// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the DMEM/IMEM round-robin arbiters.
// Consumed by rr_picker and dmem_rr_arbiter.
package dmem_arb_pkg;

  localparam int PERF_CNT_W = 32;
  localparam int MAX_PORTS  = 8;

  // Width of a port index; never less than one bit so NUM_PORTS=1 still has a sel register.
  function automatic int sel_width(input int n);
    if (n <= 2)
      return 1;
    else if (n <= 4)
      return 2;
    else
      return 3;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index searching upward
// from last_grant+1, wrapping modulo N. Shared with the IMEM arbiter.
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [SEL_W-1:0] last_grant,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin DMEM front end: ARB -> ACCESS -> ACK pipeline with per-port busy masking.
// Optional per-port grant/stall counters when DMEM_ARB_PERF_EN is defined.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [NUM_PORTS*PERF_CNT_W-1:0] perf_grants,
  output logic [NUM_PORTS*PERF_CNT_W-1:0] perf_stalls,
`endif
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int SEL_W = sel_width(NUM_PORTS);

  logic [NUM_PORTS-1:0] busy;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [NUM_PORTS-1:0] sel_oh;
  logic [SEL_W-1:0]     sel;
  logic [SEL_W-1:0]     last_grant;
  logic [SEL_W-1:0]     grant_idx;
  logic                 sel_valid;
  logic                 grant_valid;
  logic                 access_ok;
  logic                 we_sel;
  logic [ADDR_W-1:0]    addr_sel;
  logic [ADDR_W-1:0]    addr_hold;
  logic [DATA_W-1:0]    wdata_sel;
  logic [DATA_W-1:0]    wdata_hold;

  assign eligible = req & ~busy;

  rr_picker #(.N(NUM_PORTS), .SEL_W(SEL_W)) u_picker (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    sel_oh    = '0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SEL_W'(i)) begin
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
        we_sel    = we[i];
        sel_oh[i] = 1'b1;
      end
      if (grant_valid && grant_idx == SEL_W'(i))
        grant_oh[i] = 1'b1;
    end
  end

  // Reset gates the ACCESS stage directly so an in-flight write never commits.
  assign access_ok = sel_valid & ~reset;
  assign mem_en    = access_ok;
  assign mem_we    = access_ok & we_sel;
  assign mem_addr  = access_ok ? addr_sel  : addr_hold;
  assign mem_wdata = access_ok ? wdata_sel : wdata_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_valid  <= 1'b0;
      sel        <= '0;
      last_grant <= SEL_W'(NUM_PORTS - 1);
      busy       <= '0;
      ack        <= '0;
      rdata      <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      sel_valid <= grant_valid;
      if (grant_valid) begin
        sel        <= grant_idx;
        last_grant <= grant_idx;
      end
      // A port stays busy through ACCESS and ACK; its slot frees on the ACK edge.
      busy <= (busy & ~ack) | grant_oh;
      ack  <= sel_valid ? sel_oh : '0;
      if (sel_valid) begin
        addr_hold  <= addr_sel;
        wdata_hold <= wdata_sel;
        if (!we_sel)
          rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_oh[i])
          perf_grants[i*PERF_CNT_W +: PERF_CNT_W] <= perf_grants[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
        if (eligible[i] && !grant_oh[i])
          perf_stalls[i*PERF_CNT_W +: PERF_CNT_W] <= perf_stalls[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Scoreboard bench for dmem_rr_arbiter (3 ports); perf counters checked when DMEM_ARB_PERF_EN is defined.
module tb_dmem_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_en, mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [N*32-1:0] perf_grants, perf_stalls;
`endif

  dmem_rr_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef DMEM_ARB_PERF_EN
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls),
`endif
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DMEM model: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return 32'h1000_0000 | {24'h0, a};
  endfunction

  typedef struct { int port; int cyc; bit rd; logic [31:0] data; } ack_t;
  typedef struct { logic [31:0] addr; bit wr; logic [31:0] data; } acc_t;
  ack_t exp_ack[$];
  acc_t exp_acc[$];

  int n_cmp = 0, n_bad = 0, n_we = 0, n_acks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ack(input int p, input int c, input bit rd, input logic [31:0] d);
    ack_t e;
    e.port = p; e.cyc = c; e.rd = rd; e.data = d;
    exp_ack.push_back(e);
  endtask

  task automatic push_acc(input logic [31:0] a, input bit wr, input logic [31:0] d);
    acc_t e;
    e.addr = a; e.wr = wr; e.data = d;
    exp_acc.push_back(e);
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    req[p] = r;
    we[p]  = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack or a DMEM access.
  always @(negedge clk) begin
    if (mem_we) n_we++;
    if (|ack) begin
      n_acks++;
      chk("ack_onehot", 64'($onehot(ack)), 64'd1);
      if (exp_ack.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_ack: got %0h expected none (cycle %0d)", ack, cyc);
      end else begin
        ack_t e;
        e = exp_ack.pop_front();
        chk("ack_port", 64'(ack), 64'(1 << e.port));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) chk("rdata", 64'(rdata), 64'(e.data));
      end
    end
    if (mem_en) begin
      if (exp_acc.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_access: got addr %0h expected none (cycle %0d)", mem_addr, cyc);
      end else begin
        acc_t a;
        a = exp_acc.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(a.addr));
        chk("mem_we", 64'(mem_we), 64'(a.wr));
        if (a.wr) chk("mem_wdata", 64'(mem_wdata), 64'(a.data));
      end
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, we0;
    req = '0; we = '0; addr = '0; wdata = '0; reset = 1'b0;
    reset_dut();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    // Port 0: write 0x10 then read it back.
    tick(); c = cyc; we0 = n_we;
    set_port(0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    push_acc(32'h10, 1, 32'hDEAD_BEEF); push_ack(0, c + 2, 0, 0);
    push_acc(32'h10, 0, 0);             push_ack(0, c + 5, 1, 32'hDEAD_BEEF);
    tick(3);
    set_port(0, 1, 0, 32'h10, 0);
    tick(3);
    set_port(0, 0, 0, 0, 0);
    tick(2);
    chk("single_write_we_cycles", 64'(n_we - we0), 64'd1);

    // Two ports in the same cycle after reset.
    reset_dut();
    tick(); c = cyc;
    set_port(0, 1, 0, 32'h20, 0);
    set_port(1, 1, 0, 32'h24, 0);
    push_acc(32'h20, 0, 0); push_ack(0, c + 2, 1, init_val(8'h20));
    push_acc(32'h24, 0, 0); push_ack(1, c + 3, 1, init_val(8'h24));
    tick(3); set_port(0, 0, 0, 0, 0);
    tick();  set_port(1, 0, 0, 0, 0);
    tick(2);

    // Three ports continuously: strict rotation 0,1,2 for 12 grants.
    reset_dut();
    tick(); c = cyc;
    for (int p = 0; p < N; p++) set_port(p, 1, 0, 32'h40 + 4 * p, 0);
    for (int k = 0; k < 12; k++) begin
      push_acc(32'h40 + 4 * (k % 3), 0, 0);
      push_ack(k % 3, c + k + 2, 1, init_val(8'(8'h40 + 4 * (k % 3))));
    end
    tick(12); set_port(0, 0, 0, 0, 0);
    tick();   set_port(1, 0, 0, 0, 0);
    tick();   set_port(2, 0, 0, 0, 0);
    tick(2);

    // Port 1 back-to-back: one access every 3 cycles.
    tick(); c = cyc;
    set_port(1, 1, 0, 32'h80, 0);
    for (int k = 0; k < 3; k++) begin
      push_acc(32'h80 + 4 * k, 0, 0);
      push_ack(1, c + 2 + 3 * k, 1, init_val(8'(8'h80 + 4 * k)));
    end
    tick(3); set_port(1, 1, 0, 32'h84, 0);
    tick(3); set_port(1, 1, 0, 32'h88, 0);
    tick(3); set_port(1, 0, 0, 0, 0);
    tick(2);

    // Reset during the ACCESS cycle of a port-0 write.
    tick(); we0 = n_we;
    set_port(0, 1, 1, 32'h30, 32'hBAD0_BAD0);
    tick(); reset = 1'b1; set_port(0, 0, 0, 0, 0);
    tick(); reset = 1'b0;
    tick();
    chk("abort_mem_unchanged", 64'(mem[8'h30]), 64'(init_val(8'h30)));
    chk("abort_no_we", 64'(n_we - we0), 64'd0);
    c = cyc;
    set_port(0, 1, 0, 32'h34, 0);
    set_port(1, 1, 0, 32'h38, 0);
    push_acc(32'h34, 0, 0); push_ack(0, c + 2, 1, init_val(8'h34));
    push_acc(32'h38, 0, 0); push_ack(1, c + 3, 1, init_val(8'h38));
    tick(3); set_port(0, 0, 0, 0, 0);
    tick();  set_port(1, 0, 0, 0, 0);
    tick(2);

`ifdef DMEM_ARB_PERF_EN
    begin
      int a0;
      int gp[7];
      int gc[7];
      reset_dut();
      tick(); c = cyc; a0 = n_acks;
      set_port(0, 1, 0, 32'h50, 0);
      set_port(1, 1, 0, 32'h54, 0);
      gp = '{0, 1, 0, 1, 0, 1, 0};
      gc = '{0, 1, 3, 4, 6, 7, 9};
      for (int k = 0; k < 7; k++) begin
        push_acc(32'h50 + 4 * gp[k], 0, 0);
        push_ack(gp[k], c + gc[k] + 2, 1, init_val(8'(8'h50 + 4 * gp[k])));
      end
      tick(10); set_port(1, 0, 0, 0, 0);
      tick(2);  set_port(0, 0, 0, 0, 0);
      tick(2);
      chk("perf_grants0", 64'(perf_grants[0 +: 32]), 64'd4);
      chk("perf_grants1", 64'(perf_grants[32 +: 32]), 64'd3);
      chk("perf_grants2", 64'(perf_grants[64 +: 32]), 64'd0);
      chk("perf_grant_sum", 64'(perf_grants[0 +: 32] + perf_grants[32 +: 32] + perf_grants[64 +: 32]),
          64'(n_acks - a0));
      chk("perf_stalls0", 64'(perf_stalls[0 +: 32]), 64'd0);
      chk("perf_stalls1", 64'(perf_stalls[32 +: 32]), 64'd1);
      chk("perf_stalls2", 64'(perf_stalls[64 +: 32]), 64'd0);
    end
`endif

    tick(3);
    chk("pending_acks", 64'(exp_ack.size()), 64'd0);
    chk("pending_accesses", 64'(exp_acc.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Parametrised data-memory front end for the multi-core SoC generation.
- Lets NUM_PORTS requesters (cores, DMA) share one DMEM instance that has a combinational read and a synchronous write.
- Uses round-robin arbitration, a req/ack handshake and registered responses.
- Sits between the Core instances and DMEM at SoC level.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port request, level.
- we  in  NUM_PORTS  per-port write enable, qualified by req.
- addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  per-port write data, packed the same way.
- ack  out  NUM_PORTS  one-cycle completion pulse per port.
- rdata  out  DATA_W  shared read data, valid for the port whose ack is high.
- mem_en  out  1  DMEM access valid this cycle.
- mem_we  out  1  DMEM write enable.
- mem_addr  out  ADDR_W  DMEM address.
- mem_wdata  out  DATA_W  DMEM write data.
- mem_rdata  in  DATA_W  DMEM combinational read data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, internal sel_valid=0, last_grant=NUM_PORTS-1, so port 0 wins first.
- Handshake:
  - A requester raises req with we/addr/wdata and holds them stable until the cycle ack[i]=1.
  - req high in the cycle after ack is a new request.
  - Requester drops req on the edge after ack if idle.
- Pipeline:
  - Cycle t (ARB): eligible = req & ~busy. Winner = first eligible index searching upward from last_grant+1, modulo NUM_PORTS. At the t edge register sel and sel_valid, set busy[sel], and update last_grant.
  - Cycle t+1 (ACCESS): mem_en=sel_valid. mem_we, mem_addr, mem_wdata are driven combinationally from the registered sel port's inputs. DMEM write commits on the t+1 edge. On that edge rdata <= mem_rdata (reads only; writes hold the previous rdata) and ack[sel] <= 1.
  - Cycle t+2 (ACK): ack[sel]=1 for exactly one cycle; clear busy[sel] at the end of this cycle.
- Timing:
  - Latency: req first seen in cycle t gives ack in cycle t+2.
  - Throughput: one access per cycle across distinct ports.
  - A single port can issue at most one access per 3 cycles, because busy masks it during ACCESS and ACK.
- When sel_valid=0: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last value.
- Simultaneous requests: exactly one grant per cycle, with strict rotation. With all ports requesting continuously, grants cycle 0,1,..,N-1,0.
- Single requester: always wins whenever eligible, regardless of last_grant.
- req dropped before ack is a protocol violation. The granted access still completes and ack still pulses.
- Reset mid-operation:
  - An in-flight access is abandoned and no ack is issued.
  - mem_we=0 in the reset cycle and the following cycle, so no write commits.
  - last_grant returns to NUM_PORTS-1.
- NUM_PORTS=1: degenerates to the same pipeline, with no arbitration delay beyond the ARB register.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants [NUM_PORTS*32]: per-port grant counters, +1 per grant, wrap at 2^32.
  - Adds output perf_stalls [NUM_PORTS*32]: +1 each cycle a port has req&~busy but is not granted.
  - Both counters clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg: PERF_CNT_W=32, max-port constant 8, and a helper function computing log2 of NUM_PORTS for the sel width.
- Sub-module rr_picker: purely combinational, (eligible, last_grant) -> (grant_valid, grant_idx). It is reused later by the IMEM arbiter.

Test Plan:
- Single write then read, port 0: write addr=0x10, wdata=0xDEADBEEF, then read addr=0x10 -> ack[0] at t+2 both times, rdata=0xDEADBEEF, mem_we high in exactly one cycle.
- Two ports request in the same cycle after reset -> port 0 acked at t+2, port 1 acked at t+3, mem_addr matches each in its ACCESS cycle.
- Three ports hold req continuously for 12 cycles with NUM_PORTS=3 -> grant order 0,1,2,0,1,2..., each port gets 4 acks ±1, no ack overlap.
- Port 1 issues back-to-back reads while port 0 is idle -> acks at t+2, t+5, t+8; never two accesses for port 1 inside 3 cycles.
- Reset asserted in an ACCESS cycle with we=1 -> no ack, memory location unchanged, the next request is granted to port 0.
- DMEM_ARB_PERF_EN defined, two ports contending for 10 cycles -> perf_grants sum equals total acks, perf_stalls matches the count of eligible-but-not-granted cycles computed by the bench model.
